// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates the two-digit display between balance, price,
// change and error messages. Each latched message is held for HOLD_CYCLES;
// the live balance is shown whenever no message is held.
// Optional feature macro: DISP_BLINK_EN (error code blinks with half-period
// BLINK_CYCLES). Without it disp_blank is tied low.
module display_scheduler #(
  parameter int HOLD_CYCLES  = 100,
  parameter int BLINK_CYCLES = 10,
  parameter int MAX_SHOW     = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] bal_val,
  input  logic       price_req,
  input  logic [8:0] price_val,
  input  logic       chg_req,
  input  logic [8:0] chg_val,
  input  logic       err_req,
  input  logic [8:0] err_code,
  output logic       price_ack,
  output logic       chg_ack,
  output logic       err_ack,
  output logic [8:0] disp_data,
  output logic [1:0] disp_src,
  output logic       disp_blank,
  output logic       busy
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam int TW = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] TLOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [8:0] SAT_MAX = 9'(MAX_SHOW);

  localparam logic [1:0] SRC_BAL   = 2'd0;
  localparam logic [1:0] SRC_PRICE = 2'd1;
  localparam logic [1:0] SRC_CHG   = 2'd2;
  localparam logic [1:0] SRC_ERR   = 2'd3;

  function automatic logic [8:0] sat(input logic [8:0] v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [8:0]    data_q, data_nxt;
  logic [1:0]    src_q, src_nxt;
  logic [2:0]    ack_q, ack_nxt;   // {err, chg, price}

  logic          any_req;
  logic [1:0]    win_src;
  logic [8:0]    win_val;
  logic          do_latch;

  // Fixed-priority winner among the pending requests: err > chg > price.
  always_comb begin
    any_req = err_req | chg_req | price_req;
    win_src = SRC_PRICE;
    win_val = sat(price_val);
    if (err_req) begin
      win_src = SRC_ERR;
      win_val = sat(err_code);
    end else if (chg_req) begin
      win_src = SRC_CHG;
      win_val = sat(chg_val);
    end
  end

  // Next-state logic: hold/expire the current message, latch a winner, or track the balance.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    data_nxt  = data_q;
    src_nxt   = src_q;
    ack_nxt   = 3'b000;
    do_latch  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          do_latch = 1'b1;
        end else begin
          data_nxt = sat(bal_val);
          src_nxt  = SRC_BAL;
        end
      end
      SHOW: begin
        if (timer == '0) begin
          if (any_req) begin
            do_latch = 1'b1;
          end else begin
            state_nxt = IDLE;
            data_nxt  = sat(bal_val);
            src_nxt   = SRC_BAL;
          end
        end else if (err_req && src_q != SRC_ERR) begin
          // An error cuts short a price or change message.
          do_latch = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (do_latch) begin
      state_nxt = SHOW;
      timer_nxt = TLOAD;
      data_nxt  = win_val;
      src_nxt   = win_src;
      ack_nxt   = {win_src == SRC_ERR, win_src == SRC_CHG, win_src == SRC_PRICE};
    end
  end

  // State and display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      data_q <= '0;
      src_q  <= SRC_BAL;
      ack_q  <= 3'b000;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      data_q <= data_nxt;
      src_q  <= src_nxt;
      ack_q  <= ack_nxt;
    end
  end

  assign disp_data = data_q;
  assign disp_src  = src_q;
  assign busy      = (state == SHOW);
  assign price_ack = ack_q[0];
  assign chg_ack   = ack_q[1];
  assign err_ack   = ack_q[2];

`ifdef DISP_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blank_q;

  // Blink phase restarts on every error latch and runs only while the error is shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blank_q   <= 1'b0;
    end else if ((do_latch && win_src == SRC_ERR) || src_nxt != SRC_ERR) begin
      blink_cnt <= '0;
      blank_q   <= 1'b0;
    end else if (blink_cnt == BLAST) begin
      blink_cnt <= '0;
      blank_q   <= ~blank_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign disp_blank = blank_q;
`else
  assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed scenarios followed by randomized requesters,
// all checked every cycle against a message-level reference model.
module tb_display_scheduler;

  localparam int HOLD  = 20;
  localparam int BLINK = 4;
  localparam int MAXS  = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] bal_val = '0;
  logic       price_req = 1'b0;
  logic [8:0] price_val = '0;
  logic       chg_req = 1'b0;
  logic [8:0] chg_val = '0;
  logic       err_req = 1'b0;
  logic [8:0] err_code = '0;
  logic       price_ack, chg_ack, err_ack;
  logic [8:0] disp_data;
  logic [1:0] disp_src;
  logic       disp_blank;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  display_scheduler #(
    .HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK), .MAX_SHOW(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .bal_val(bal_val),
    .price_req(price_req), .price_val(price_val),
    .chg_req(chg_req), .chg_val(chg_val),
    .err_req(err_req), .err_code(err_code),
    .price_ack(price_ack), .chg_ack(chg_ack), .err_ack(err_ack),
    .disp_data(disp_data), .disp_src(disp_src),
    .disp_blank(disp_blank), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: the message on the display and how many cycles it has been up.
  bit       m_busy = 0;
  int       m_src = 0;
  int       m_val = 0;
  int       m_shown = 0;
  bit [2:0] m_ack = 3'b000;

  function automatic int sat(input int v);
    return (v > MAXS) ? MAXS : v;
  endfunction

  always @(posedge clk) begin
    int pick;
    int v;
    m_ack = 3'b000;
    if (rst) begin
      m_busy = 0; m_src = 0; m_val = 0; m_shown = 0;
    end else begin
      pick = err_req ? 3 : chg_req ? 2 : price_req ? 1 : 0;
      v    = err_req ? int'(err_code) : chg_req ? int'(chg_val) : int'(price_val);
      if (pick != 0 && (!m_busy || m_shown == HOLD || (pick == 3 && m_src != 3))) begin
        m_busy = 1; m_src = pick; m_val = sat(v); m_shown = 1;
        m_ack[pick-1] = 1'b1;
      end else if (m_busy && m_shown < HOLD) begin
        m_shown++;
      end else begin
        m_busy = 0; m_src = 0; m_val = sat(int'(bal_val)); m_shown = 0;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Advance one cycle, compare every output, and let requesters drop req after ack.
  task automatic tick();
    int exp_blank;
    @(negedge clk);
`ifdef DISP_BLINK_EN
    exp_blank = (m_src == 3) ? ((m_shown - 1) / BLINK) % 2 : 0;
`else
    exp_blank = 0;
`endif
    chk("disp_data", int'(disp_data), m_val);
    chk("disp_src", int'(disp_src), m_src);
    chk("busy", int'(busy), int'(m_busy));
    chk("acks", int'({err_ack, chg_ack, price_ack}), int'(m_ack));
    chk("disp_blank", int'(disp_blank), exp_blank);
    if (price_ack) price_req = 1'b0;
    if (chg_ack)   chg_req   = 1'b0;
    if (err_ack)   err_req   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset, then idle balance display with saturation.
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    bal_val = 9'd14;
    run(3);
    bal_val = 9'd250;
    run(2);
    bal_val = 9'd14;
    run(2);

    // Single price message, full hold then back to balance.
    price_val = 9'd35; price_req = 1'b1;
    run(HOLD + 4);

    // Simultaneous chg/price: chg first (saturated), price directly after.
    chg_val = 9'd120; chg_req = 1'b1; price_req = 1'b1;
    run(2 * HOLD + 4);

    // Error preempts a price hold mid-way.
    price_val = 9'd42; price_req = 1'b1;
    run(8);
    err_code = 9'd7; err_req = 1'b1;
    run(HOLD + 4);

    // Reset in the middle of a hold with a change request pending.
    price_val = 9'd50; price_req = 1'b1;
    run(3);
    chg_val = 9'd60; chg_req = 1'b1;
    run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(2 * HOLD + 4);

    // Back-to-back errors exercise blink restart on re-latch.
    err_code = 9'd300; err_req = 1'b1;
    run(HOLD);
    err_code = 9'd9; err_req = 1'b1;
    run(HOLD + 4);

    // Randomized requesters.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) bal_val = 9'($urandom_range(0, 511));
      if (!price_req && $urandom_range(0, 7) == 0) begin
        price_val = 9'($urandom_range(0, 511)); price_req = 1'b1;
      end
      if (!chg_req && $urandom_range(0, 11) == 0) begin
        chg_val = 9'($urandom_range(0, 511)); chg_req = 1'b1;
      end
      if (!err_req && $urandom_range(0, 29) == 0) begin
        err_code = 9'($urandom_range(0, 511)); err_req = 1'b1;
      end
      if (price_req && $urandom_range(0, 199) == 0) price_req = 1'b0;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
